// File: rtl/tmr_fault_injector.sv
// Triplicates a payload through one output register and XOR-corrupts one copy on an FSM-chosen transfer.
// Optional build macro TMR_FI_STUCK_EN enables stuck mode (corrupt every transfer until re-armed).
module tmr_fault_injector #(
  parameter int BIT   = 8,
  parameter int DLY_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BIT-1:0]          data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [2:0][BIT-1:0]     data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    arm_i,
  input  logic [1:0]              cfg_copy_i,
  input  logic [BIT-1:0]          cfg_mask_i,
  input  logic [DLY_W-1:0]        cfg_delay_i,
  input  logic                    cfg_stuck_i,
  output logic                    busy_o,
  output logic                    injected_o,
  output logic [15:0]             inj_count_o
);

`ifdef TMR_FI_STUCK_EN
  localparam logic STUCK_EN = 1'b1;
`else
  localparam logic STUCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;

  state_t             state;
  logic [1:0]         copy_q;
  logic [BIT-1:0]     mask_q;
  logic [DLY_W-1:0]   cnt_q;
  logic               stuck_q;

  logic               in_xfer;
  logic               stuck_exit;
  logic               corrupt;
  logic [2:0][BIT-1:0] word;

  assign ready_o    = !valid_o || ready_i;
  assign in_xfer    = valid_i && ready_o;
  // Re-arming a stuck injector releases it; that cycle's transfer goes through clean.
  assign stuck_exit = (state == FIRE) && stuck_q && arm_i;
  assign corrupt    = (state == FIRE) && in_xfer && !stuck_exit;

  always_comb begin
    word = '0;
    for (int c = 0; c < 3; c++) begin
      word[c] = data_i;
      if (corrupt && (copy_q == 2'(c)))
        word[c] = data_i ^ mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      copy_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      stuck_q     <= 1'b0;
      valid_o     <= 1'b0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      injected_o  <= 1'b0;
      inj_count_o <= '0;
    end else begin
      injected_o <= corrupt;
      if (corrupt && (inj_count_o != 16'hFFFF))
        inj_count_o <= inj_count_o + 16'd1;

      if (in_xfer) begin
        valid_o <= 1'b1;
        data_o  <= word;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arm_i) begin
            copy_q  <= cfg_copy_i;
            mask_q  <= cfg_mask_i;
            cnt_q   <= cfg_delay_i;
            stuck_q <= STUCK_EN & cfg_stuck_i;
            busy_o  <= 1'b1;
            state   <= (cfg_delay_i != '0) ? COUNT : FIRE;
          end
        end
        COUNT: begin
          if (in_xfer) begin
            cnt_q <= cnt_q - DLY_W'(1);
            if (cnt_q == DLY_W'(1))
              state <= FIRE;
          end
        end
        FIRE: begin
          if (stuck_exit || (in_xfer && !stuck_q)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Scoreboard bench for tmr_fault_injector: a transfer-level model predicts each triplicated word.
module tb_tmr_fault_injector;
  localparam int BIT   = 8;
  localparam int DLY_W = 8;
`ifdef TMR_FI_STUCK_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  typedef logic [2:0][BIT-1:0] trip_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BIT-1:0]   data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  trip_t            data_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic             arm_i = 1'b0;
  logic [1:0]       cfg_copy_i = '0;
  logic [BIT-1:0]   cfg_mask_i = '0;
  logic [DLY_W-1:0] cfg_delay_i = '0;
  logic             cfg_stuck_i = 1'b0;
  logic             busy_o;
  logic             injected_o;
  logic [15:0]      inj_count_o;

  tmr_fault_injector #(.BIT(BIT), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .arm_i(arm_i),
    .cfg_copy_i(cfg_copy_i), .cfg_mask_i(cfg_mask_i), .cfg_delay_i(cfg_delay_i),
    .cfg_stuck_i(cfg_stuck_i), .busy_o(busy_o), .injected_o(injected_o),
    .inj_count_o(inj_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  trip_t sb[$];

  // Transfer-level model: "armed with N clean transfers still to let through".
  bit         m_chk = 1'b0;
  bit         m_occ, m_armed, m_stuck, m_inj;
  int         m_left, m_cnt;
  logic [1:0] m_copy;
  logic [7:0] m_mask;
  bit         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit va, input logic [7:0] d, input bit rd,
                      input bit ar, input logic [1:0] cp, input logic [7:0] mk,
                      input int dl, input bit st);
    bit    corrupt;
    trip_t t;
    @(posedge clk);
    #1;
    rst_n = rn; valid_i = va; data_i = d; ready_i = rd; arm_i = ar;
    cfg_copy_i = cp; cfg_mask_i = mk; cfg_delay_i = DLY_W'(dl); cfg_stuck_i = st;
    @(negedge clk);
    if (m_chk) begin
      chk("valid_o", {31'd0, valid_o}, {31'd0, m_occ});
      chk("ready_o", {31'd0, ready_o}, {31'd0, (!m_occ || rd)});
      chk("busy_o", {31'd0, busy_o}, {31'd0, m_armed});
      chk("injected_o", {31'd0, injected_o}, {31'd0, m_inj});
      chk("inj_count_o", {16'd0, inj_count_o}, m_cnt);
    end
    if (!rn) begin
      m_occ = 0; m_armed = 0; m_inj = 0; m_cnt = 0; m_left = 0;
      sb.delete();
      m_chk = 1'b1;
      last_acc = 1'b0;
    end else begin
      last_acc = va && (!m_occ || rd);
      corrupt = 1'b0;
      if (!m_armed) begin
        if (ar) begin
          m_armed = 1; m_left = dl; m_copy = cp; m_mask = mk; m_stuck = st;
        end
      end else if (STUCK_EN && m_stuck && m_left == 0 && ar) begin
        m_armed = 0;
      end else if (last_acc) begin
        if (m_left > 0) m_left--;
        else begin
          corrupt = 1'b1;
          if (!(STUCK_EN && m_stuck)) m_armed = 0;
        end
      end
      if (last_acc) begin
        t = {d, d, d};
        if (corrupt && m_copy != 2'd3) t[m_copy] = d ^ m_mask;
        sb.push_back(t);
      end
      m_inj = corrupt;
      if (corrupt && m_cnt < 65535) m_cnt++;
      m_occ = last_acc || (m_occ && !rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0);
  endtask

  task automatic arm(input logic [1:0] cp, input logic [7:0] mk, input int dl, input bit st);
    step(1, 0, 8'h00, 1, 1, cp, mk, dl, st);
  endtask

  task automatic send(input logic [7:0] d);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 1, d, 1, 0, 2'd0, 8'h00, 0, 0);
      done = last_acc;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold during stalls.
  initial begin
    bit    stall_prev = 1'b0;
    trip_t held = '0;
    forever begin
      @(negedge clk);
      if (m_chk && rst_n) begin
        if (stall_prev) begin
          chk("stall_valid", {31'd0, valid_o}, 32'd1);
          chk("stall_data", {8'd0, data_o}, {8'd0, held});
        end
        if (valid_o && ready_i) begin
          if (sb.size() == 0) chk("unexpected_word", {8'd0, data_o}, 32'hFFFFFFFF);
          else chk("data_o", {8'd0, data_o}, {8'd0, sb.pop_front()});
        end
        stall_prev = valid_o && !ready_i;
        held = data_o;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    // Reset with valid_i high.
    step(0, 1, 8'hAA, 1, 0, 2'd0, 8'h00, 0, 0);
    step(0, 1, 8'hAA, 1, 0, 2'd0, 8'h00, 0, 0);
    idle(1);

    arm(2'd0, 8'h04, 0, 0);
    send(8'h25);
    idle(2);

    arm(2'd2, 8'hFF, 3, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    step(1, 0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0);
    send(8'h05);
    idle(2);

    arm(2'd3, 8'h5A, 0, 0);
    send(8'h45);
    idle(2);

    // Arm and transfer in the same cycle: that word stays clean.
    step(1, 1, 8'h11, 1, 1, 2'd1, 8'h0F, 1, 0);
    send(8'h12); send(8'h13);
    idle(2);

    // Reset in COUNT with two transfers left.
    arm(2'd1, 8'h3C, 4, 0);
    send(8'h20); send(8'h21);
    step(0, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    idle(2);

    // Stuck-mode request (single-shot when the feature is compiled out).
    arm(2'd1, 8'h80, 0, 1);
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
    arm(2'd0, 8'h00, 0, 0);
    idle(1);
    send(8'h60); send(8'h61);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 150) != 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0,
           ($urandom % 10) == 0, 2'($urandom), 8'($urandom), int'($urandom % 5),
           1'($urandom));
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
